hack_data_memory: RTL

Data-memory responder for the Hack CPU bus. It serves CPU reads and writes on addressM, outM, writeM and inM, and decodes the 15-bit space into RAM, a screen region and a keyboard register. Screen writes are mirrored into a shadow array and queued in a FIFO toward the display controller over a valid/ready handshake. Keyboard codes are latched from the keyboard interface.

---
 rtl/hack_data_memory_if.sv | 26 ++
 rtl/hack_data_memory.sv | 115 +++++++++++
 2 files changed

// File: rtl/hack_data_memory_if.sv
// Hack CPU data bus plus screen-update stream and keyboard strobe.
// master = CPU/system side, slave = hack_data_memory.
interface hack_data_memory_if;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic        scr_valid;
  logic        scr_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        scr_overflow;
  logic        ovf_clr;

  modport master (
    output addressM, outM, writeM, scr_ready, kbd_valid, kbd_code, ovf_clr,
    input  inM, scr_valid, scr_addr, scr_data, scr_overflow
  );

  modport slave (
    input  addressM, outM, writeM, scr_ready, kbd_valid, kbd_code, ovf_clr,
    output inM, scr_valid, scr_addr, scr_data, scr_overflow
  );
endinterface

// File: rtl/hack_data_memory.sv
// Hack data memory: RAM, screen shadow with an update FIFO toward the display,
// and a read-only keyboard register. CPU reads are combinational.
module hack_data_memory #(
  parameter int unsigned RAM_WORDS      = 16384,
  parameter int unsigned SCR_WORDS      = 8192,
  parameter int unsigned SCR_FIFO_DEPTH = 8,
  parameter int unsigned KBD_ADDR       = 24576
) (
  input  logic               clk,
  input  logic               rst_n,
  hack_data_memory_if.slave  io_bus
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned ScrAw = $clog2(SCR_WORDS);
  localparam int unsigned PtrW  = $clog2(SCR_FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam logic [14:0]     KbdAddr  = KBD_ADDR[14:0];
  localparam logic [CntW-1:0] FifoFull = CntW'(SCR_FIFO_DEPTH);

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCR_WORDS];
  logic [12:0] r_fifo_addr [SCR_FIFO_DEPTH];
  logic [15:0] r_fifo_data [SCR_FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic            r_overflow;
  logic [15:0]     r_kbd;

  logic        w_sel_ram;
  logic        w_sel_scr;
  logic        w_sel_kbd;
  logic        w_scr_wr;
  logic        w_full;
  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic        w_ovf_set;
  logic [15:0] w_rdata;

  assign w_sel_ram = ~io_bus.addressM[14];
  assign w_sel_scr = (io_bus.addressM[14:13] == 2'b10);
  assign w_sel_kbd = (io_bus.addressM == KbdAddr);

  assign w_full    = (r_count == FifoFull);
  assign w_valid   = (r_count != '0);
  assign w_pop     = w_valid & io_bus.scr_ready;
  assign w_scr_wr  = rst_n & io_bus.writeM & w_sel_scr;
  // A full FIFO still accepts the write when its head leaves on the same edge.
  assign w_push    = w_scr_wr & (~w_full | w_pop);
  assign w_ovf_set = w_scr_wr & w_full & ~w_pop;

  always_comb begin
    w_rdata = '0;
    if (w_sel_ram) begin
      w_rdata = r_ram[io_bus.addressM[RamAw-1:0]];
    end else if (w_sel_scr) begin
      w_rdata = r_scr[io_bus.addressM[ScrAw-1:0]];
    end else if (w_sel_kbd) begin
      w_rdata = r_kbd;
    end
  end

  assign io_bus.inM          = w_rdata;
  assign io_bus.scr_valid    = w_valid;
  assign io_bus.scr_addr     = r_fifo_addr[r_rd_ptr];
  assign io_bus.scr_data     = r_fifo_data[r_rd_ptr];
  assign io_bus.scr_overflow = r_overflow;

  // Array contents are deliberately not reset so they survive a CPU reset.
  always_ff @(posedge clk) begin
    if (rst_n && io_bus.writeM && w_sel_ram) begin
      r_ram[io_bus.addressM[RamAw-1:0]] <= io_bus.outM;
    end
    if (w_scr_wr) begin
      r_scr[io_bus.addressM[ScrAw-1:0]] <= io_bus.outM;
    end
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= io_bus.addressM[12:0];
      r_fifo_data[r_wr_ptr] <= io_bus.outM;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_kbd      <= '0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (io_bus.ovf_clr) begin
        r_overflow <= 1'b0;
      end
      if (io_bus.kbd_valid) r_kbd <= io_bus.kbd_code;
    end
  end

endmodule
